adder_result_accumulator: RTL and testbench

//  Downstream stage of the registered 3-bit parallel adder: consumes its {Cout,Sum} result (0..15).

---
 rtl/adder_pkg.sv | 11 +
 rtl/sat_add.sv | 18 +
 rtl/adder_result_accumulator.sv | 81 ++++++++
 tb/tb_adder_result_accumulator.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the adder result path: result width and accumulator FSM encoding.
package adder_pkg;
   localparam int RES_W = 3;
   localparam int RW    = RES_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2
   } state_t;
endpackage

// File: rtl/sat_add.sv
// Saturating add of one adder result into the accumulator; clip flags that the true sum overflowed.
module sat_add #(
   parameter int ACC_W = 8,
   parameter int RW    = adder_pkg::RW
) (
   input  logic [ACC_W-1:0] acc,
   input  logic [RW-1:0]    val,
   output logic [ACC_W-1:0] sum,
   output logic             clip
);

   logic [ACC_W:0] full;

   assign full = {1'b0, acc} + {{(ACC_W + 1 - RW){1'b0}}, val};
   assign clip = full[ACC_W];
   assign sum  = clip ? {ACC_W{1'b1}} : full[ACC_W-1:0];

endmodule

// File: rtl/adder_result_accumulator.sv
// Accumulates a programmed burst of adder results with saturation and hands the total off via valid/ready.
//  state    | meaning
//  ST_IDLE  | waiting for start; samples arriving here are dropped and flagged
//  ST_ACCUM | consuming samples until the remaining count reaches zero
//  ST_DONE  | total presented on acc_out/sat until out_ready
module adder_result_accumulator import adder_pkg::*; #(
   parameter int RES_W = 3,
   parameter int ACC_W = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] len,
   input  logic             in_valid,
   input  logic [RES_W-1:0] in_sum,
   input  logic             in_cout,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] acc_out,
   output logic             sat,
   output logic             overrun,
   output logic             busy
);

   state_t           state_q;
   logic [CNT_W-1:0] remaining_q;
   logic [ACC_W-1:0] sum_nxt;
   logic             clip;

   sat_add #(
      .ACC_W (ACC_W),
      .RW    (RES_W + 1)
   ) u_sat_add (
      .acc  (acc_out),
      .val  ({in_cout, in_sum}),
      .sum  (sum_nxt),
      .clip (clip)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         remaining_q <= '0;
         acc_out     <= '0;
         sat         <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         if (in_valid && (state_q != ST_ACCUM)) overrun <= 1'b1;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  acc_out     <= '0;
                  sat         <= 1'b0;
                  remaining_q <= len;
                  state_q     <= (len == '0) ? ST_DONE : ST_ACCUM;
               end
            end
            ST_ACCUM: begin
               if (in_valid) begin
                  acc_out     <= sum_nxt;
                  sat         <= sat | clip;
                  remaining_q <= remaining_q - 1'b1;
                  if (remaining_q == CNT_W'(1)) state_q <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // handshake flags decode straight from the state register, so no input reaches them combinationally
   assign in_ready  = (state_q == ST_ACCUM);
   assign out_valid = (state_q == ST_DONE);
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_adder_result_accumulator.sv
// Scoreboard bench: an 8-bit and a 4-bit accumulator share all stimulus; totals checked against a sum/clip model.
module tb_adder_result_accumulator;

   logic       clk = 1'b0;
   logic       rst, start, in_valid, in_cout, out_ready;
   logic [3:0] len;
   logic [2:0] in_sum;

   logic       in_ready, out_valid, sat, overrun, busy;
   logic [7:0] acc_out;
   logic       in_ready4, out_valid4, sat4, overrun4, busy4;
   logic [3:0] acc_out4;

   typedef struct {
      int a8;
      int s8;
      int a4;
      int s4;
   } exp_t;

   exp_t sbq[$];
   int   samp[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   last_a8  = 0;

   always #5 clk = ~clk;

   adder_result_accumulator #(.RES_W(3), .ACC_W(8), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid),
      .in_sum(in_sum), .in_cout(in_cout), .in_ready(in_ready), .out_valid(out_valid),
      .out_ready(out_ready), .acc_out(acc_out), .sat(sat), .overrun(overrun), .busy(busy)
   );

   adder_result_accumulator #(.RES_W(3), .ACC_W(4), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid),
      .in_sum(in_sum), .in_cout(in_cout), .in_ready(in_ready4), .out_valid(out_valid4),
      .out_ready(out_ready), .acc_out(acc_out4), .sat(sat4), .overrun(overrun4), .busy(busy4)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // total is the plain arithmetic sum of the burst; the register width decides where it clips
   function automatic void model(input int total, input int accw, output int a, output int s);
      int max_v;
      max_v = (1 << accw) - 1;
      if (total > max_v) begin a = max_v; s = 1; end
      else begin a = total; s = 0; end
   endfunction

   always @(negedge clk) begin
      if (rst && out_valid && out_ready) begin
         if (sbq.size() == 0) begin
            chk("sb_unexpected_total", 1, 0);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("acc8", int'(acc_out), e.a8);
            chk("sat8", int'(sat), e.s8);
            chk("acc4", int'(acc_out4), e.a4);
            chk("sat4", int'(sat4), e.s4);
            chk("out_valid4", int'(out_valid4), 1);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // n samples from samp[]; start_mid pokes start inside the burst and at handshake; dirty_done injects in_valid in DONE
   task automatic do_burst(input int n, input int ready_delay, input bit start_mid, input bit dirty_done);
      int   total;
      exp_t e;
      total = 0;
      for (int i = 0; i < n; i++) total += samp[i];
      model(total, 8, e.a8, e.s8);
      model(total, 4, e.a4, e.s4);
      sbq.push_back(e);
      start = 1'b1;
      len   = 4'(n);
      tick();
      start = 1'b0;
      if (n != 0) chk("in_ready_after_start", int'(in_ready), 1);
      for (int i = 0; i < n; i++) begin
         int gap;
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            if (start_mid && i == 1 && g == 0) begin start = 1'b1; len = 4'd0; end
            tick();
            start = 1'b0;
         end
         in_valid = 1'b1;
         {in_cout, in_sum} = 4'(samp[i]);
         tick();
         in_valid = 1'b0;
         in_sum   = 3'd0;
         in_cout  = 1'b0;
      end
      chk("out_valid_latency", int'(out_valid), 1);
      for (int d = 0; d < ready_delay; d++) begin
         if (dirty_done && d == 3) begin
            in_valid = 1'b1;
            {in_cout, in_sum} = 4'd9;
         end
         tick();
         in_valid = 1'b0;
         chk("hold_valid", int'(out_valid), 1);
         chk("hold_acc", int'(acc_out), e.a8);
      end
      out_ready = 1'b1;
      if (start_mid) begin start = 1'b1; len = 4'd3; end
      tick();
      out_ready = 1'b0;
      start     = 1'b0;
      chk("released_idle", int'(busy), 0);
      last_a8 = e.a8;
      samp.delete();
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
      in_sum = '0; in_cout = 1'b0; out_ready = 1'b0;
      repeat (3) tick();
      chk("rst_acc", int'(acc_out), 0);
      chk("rst_flags", int'({sat, overrun, busy, in_ready, out_valid}), 0);
      chk("rst_dut4", int'({acc_out4, sat4, overrun4, busy4, in_ready4, out_valid4}), 0);
      rst = 1'b1;
      tick();

      samp = '{7, 15, 2};
      do_burst(3, 0, 1'b0, 1'b0);
      chk("no_false_overrun", int'(overrun), 0);

      for (int i = 0; i < 15; i++) samp.push_back(15);
      do_burst(15, 2, 1'b0, 1'b0);
      samp = '{15, 15, 15};
      do_burst(3, 1, 1'b0, 1'b0);

      samp = '{15, 1};
      do_burst(2, 0, 1'b0, 1'b0);

      do_burst(0, 0, 1'b0, 1'b0);

      samp = '{4, 9, 11, 2};
      do_burst(4, 1, 1'b1, 1'b0);

      in_valid = 1'b1;
      in_sum   = 3'bx;
      in_cout  = 1'bx;
      tick();
      in_valid = 1'b0;
      in_sum   = '0;
      in_cout  = 1'b0;
      tick();
      chk("idle_overrun", int'(overrun), 1);
      chk("idle_acc_kept", int'(acc_out), last_a8);
      chk("idle_not_busy", int'(busy), 0);

      start = 1'b1; len = 4'd4;
      tick();
      start = 1'b0;
      in_valid = 1'b1; {in_cout, in_sum} = 4'd3;
      tick();
      {in_cout, in_sum} = 4'd6;
      tick();
      in_valid = 1'b0;
      rst = 1'b0;
      tick();
      chk("midrst_acc", int'(acc_out), 0);
      chk("midrst_flags", int'({sat, overrun, busy, in_ready, out_valid}), 0);
      chk("midrst_dut4", int'({acc_out4, busy4, overrun4}), 0);
      rst = 1'b1;
      tick();
      samp = '{5};
      do_burst(1, 0, 1'b0, 1'b0);

      samp = '{12, 3, 8};
      do_burst(3, 10, 1'b0, 1'b1);
      chk("done_overrun", int'(overrun), 1);

      for (int b = 0; b < 20; b++) begin
         int n;
         n = $urandom_range(1, 15);
         for (int i = 0; i < n; i++) samp.push_back($urandom_range(0, 15));
         do_burst(n, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
      end

      tick();
      chk("sb_drained", sbq.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
